// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key expansion: one schedule word per clock, all round keys held in storage.
// Start-to-done latency TOTAL-NK cycles; start ignored while busy; round-key read port has 1-cycle latency.

module sbox (
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out
);
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sbox_out = SBOX_TBL[{sbox_in, 3'b000} +: 8];
endmodule

module aes_key_expander #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [0:KEY_BITS-1] key_in,
  output logic                busy,
  output logic                done,
  output logic                keys_valid,
  input  logic [3:0]          rk_idx,
  output logic [0:127]        rk_out
);
  localparam int NK    = KEY_BITS / 32;
  localparam int NR    = NK + 6;
  localparam int TOTAL = 4 * (NR + 1);

  typedef enum logic {S_IDLE, S_EXPAND} state_t;

  state_t       state_q, state_d;
  logic [5:0]   i_q, i_d;
  logic [2:0]   mod_q, mod_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [31:0]  win_q [NK];
  logic [31:0]  win_d [NK];
  logic         done_q, done_d;
  logic         kv_q, kv_d;
  logic [0:127] rk_q, rk_d;
  logic [31:0]  mem_q [TOTAL];

  logic         accept;
  logic         last;
  logic [31:0]  w_prev;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  temp;
  logic [31:0]  w_new;
  logic [5:0]   rd_base;

  assign accept = (state_q == S_IDLE) && start;
  assign last   = (state_q == S_EXPAND) && (i_q == 6'(TOTAL - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_EXPAND;
      S_EXPAND: if (last)  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy       = (state_q == S_EXPAND);
    done       = done_q;
    keys_valid = kv_q;
    rk_out     = rk_q;
  end

  // One shared SubWord: RotWord is applied ahead of it only on the i mod NK == 0 step.
  assign w_prev = win_q[NK-1];
  assign sub_in = (mod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar g = 0; g < 4; g++) begin : g_sub
    sbox u_sbox (
      .sbox_in  (sub_in[8*g +: 8]),
      .sbox_out (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    temp = w_prev;
    if (mod_q == 3'd0)
      temp = sub_out ^ {rcon_q, 24'h0};
    else if (NK == 8 && mod_q == 3'd4)
      temp = sub_out;
    w_new = win_q[0] ^ temp;
  end

  always_comb begin
    i_d    = i_q;
    mod_d  = mod_q;
    rcon_d = rcon_q;
    done_d = 1'b0;
    kv_d   = kv_q;
    for (int k = 0; k < NK; k++) win_d[k] = win_q[k];

    if (accept) begin
      i_d    = 6'(NK);
      mod_d  = 3'd0;
      rcon_d = 8'h01;
      kv_d   = 1'b0;
      for (int k = 0; k < NK; k++) win_d[k] = key_in[32*k +: 32];
    end else if (state_q == S_EXPAND) begin
      i_d   = i_q + 6'd1;
      mod_d = (mod_q == 3'(NK - 1)) ? 3'd0 : mod_q + 3'd1;
      if (mod_q == 3'd0)
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      for (int k = 0; k < NK - 1; k++) win_d[k] = win_q[k+1];
      win_d[NK-1] = w_new;
      if (last) begin
        done_d = 1'b1;
        kv_d   = 1'b1;
      end
    end
  end

  assign rd_base = {rk_idx, 2'b00};

  always_comb begin
    rk_d = '0;
    if (rk_idx <= 4'(NR))
      rk_d = {mem_q[rd_base], mem_q[rd_base + 6'd1],
              mem_q[rd_base + 6'd2], mem_q[rd_base + 6'd3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q    <= '0;
      mod_q  <= '0;
      rcon_q <= '0;
      done_q <= 1'b0;
      kv_q   <= 1'b0;
      rk_q   <= '0;
      for (int k = 0; k < NK; k++) win_q[k] <= '0;
    end else begin
      i_q    <= i_d;
      mod_q  <= mod_d;
      rcon_q <= rcon_d;
      done_q <= done_d;
      kv_q   <= kv_d;
      rk_q   <= rk_d;
      for (int k = 0; k < NK; k++) win_q[k] <= win_d[k];
    end
  end

  // Storage survives reset so the last schedule stays readable.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NK; k++) mem_q[k] <= key_in[32*k +: 32];
    end else if (state_q == S_EXPAND) begin
      mem_q[i_q] <= w_new;
    end
  end
endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander: FIPS-197 vectors for all three key sizes plus handshake and reset cases.
module tb_aes_key_expander;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_v [3];
  logic [3:0]   idx_v   [3];
  logic         busy_v  [3];
  logic         done_v  [3];
  logic         kv_v    [3];
  logic [0:127] rk_v    [3];
  logic [0:127] key_a;
  logic [0:191] key_b;
  logic [0:255] key_c;

  int tests_run = 0;
  int failures  = 0;

  aes_key_expander #(.KEY_BITS(128)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .key_in(key_a),
    .busy(busy_v[0]), .done(done_v[0]), .keys_valid(kv_v[0]),
    .rk_idx(idx_v[0]), .rk_out(rk_v[0]));

  aes_key_expander #(.KEY_BITS(192)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .key_in(key_b),
    .busy(busy_v[1]), .done(done_v[1]), .keys_valid(kv_v[1]),
    .rk_idx(idx_v[1]), .rk_out(rk_v[1]));

  aes_key_expander #(.KEY_BITS(256)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .key_in(key_c),
    .busy(busy_v[2]), .done(done_v[2]), .keys_valid(kv_v[2]),
    .rk_idx(idx_v[2]), .rk_out(rk_v[2]));

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Starts expansion on instance sel and counts cycles from the accept edge to done.
  task automatic run_expand(input int sel, input int pulse_at, output int cyc);
    cyc = 0;
    @(negedge clk);
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    while (cyc < 200) begin
      if (cyc == pulse_at) begin
        start_v[sel] = 1'b1;
        if (sel == 0) key_a = '0;
      end
      @(posedge clk); #1;
      cyc++;
      start_v[sel] = 1'b0;
      if (done_v[sel]) break;
    end
  endtask

  task automatic read_rk(input int sel, input logic [3:0] idx, output logic [127:0] v);
    @(negedge clk);
    idx_v[sel] = idx;
    @(posedge clk); #1;
    v = rk_v[sel];
  endtask

  localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    int           cyc;
    logic [127:0] v;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      idx_v[k]   = 4'd0;
    end
    key_a = KEY128;
    key_b = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    key_c = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    #12;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_flags_%0d", k), 128'({busy_v[k], done_v[k], kv_v[k]}), 128'h0);
      check($sformatf("rst_rk_%0d", k), rk_v[k], 128'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Abort a run after 10 EXPAND cycles
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_flags", 128'({busy_v[0], done_v[0], kv_v[0]}), 128'h0);
    check("midrst_rk", rk_v[0], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_expand(0, -1, cyc);
    check("lat128", 128'(cyc), 128'd40);
    check("kv128", 128'({busy_v[0], kv_v[0]}), 128'b01);
    @(posedge clk); #1;
    check("done_pulse128", 128'({done_v[0], kv_v[0]}), 128'b01);
    read_rk(0, 4'd1, v);
    check("a_idx1", v, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk(0, 4'd10, v);
    check("a_idx10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(0, 4'd0, v);
    check("a_idx0", v, KEY128);
    read_rk(0, 4'd2, v);
    check("a_idx2", v, 128'hf2c295f27a96b9435935807a7359f67f);
    read_rk(0, 4'd11, v);
    check("a_idx11", v, 128'h0);

    // Start pulsed mid-run with a different key must be ignored
    run_expand(0, 5, cyc);
    check("lat_ignore", 128'(cyc), 128'd40);
    read_rk(0, 4'd10, v);
    check("ignore_idx10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Back-to-back: restart with all-zero key on the done cycle
    key_a = KEY128;
    run_expand(0, -1, cyc);
    check("lat_b2b_first", 128'(cyc), 128'd40);
    start_v[0] = 1'b1;
    key_a      = '0;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check("b2b_accept", 128'({busy_v[0], kv_v[0]}), 128'b10);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (done_v[0]) break;
    end
    check("lat_b2b", 128'(cyc), 128'd40);
    read_rk(0, 4'd1, v);
    check("zero_idx1", v, 128'h62636363626363636263636362636363);
    read_rk(0, 4'd10, v);
    check("zero_idx10", v, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // 192-bit key
    run_expand(1, -1, cyc);
    check("lat192", 128'(cyc), 128'd46);
    read_rk(1, 4'd12, v);
    check("b_idx12", v, 128'he98ba06f448c773c8ecc720401002202);
    read_rk(1, 4'd13, v);
    check("b_idx13", v, 128'h0);
    read_rk(1, 4'd1, v);
    check("b_idx1", v, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);

    // 256-bit key
    run_expand(2, -1, cyc);
    check("lat256", 128'(cyc), 128'd52);
    read_rk(2, 4'd14, v);
    check("c_idx14", v, 128'hfe4890d1e6188d0b046df344706c631e);
    read_rk(2, 4'd2, v);
    check("c_idx2", v, 128'h9ba354118e6925afa51a8b5f2067fcde);
    read_rk(2, 4'd3, v);
    check("c_idx3", v, 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
    read_rk(2, 4'd15, v);
    check("c_idx15", v, 128'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Iterative, parametrised AES key-expansion engine supporting 128-, 192- and 256-bit cipher keys. It replaces the per-round combinational key scheduler: on a start handshake it expands the cipher key into the full FIPS-197 word schedule, one 32-bit word per clock. It stores every round key internally and serves any round key on a registered read port to the round datapath. The engine instantiates the existing `sbox` module (ports `sbox_in`, `sbox_out`) for SubWord.

## Interface

Parameters:
- `KEY_BITS`, default 128: cipher key size; legal values are 128, 192 and 256. Derived: NK = KEY_BITS/32, NR = NK+6, TOTAL = 4*(NR+1) words (44, 52 or 60).

Ports (bus bit 0 is the MSB of the first key byte):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request expansion of `key_in`. Sampled only in IDLE.
- `key_in` in [0:KEY_BITS-1]: cipher key, captured on an accepted `start`.
- `busy` out 1: high while expansion is in progress.
- `done` out 1: one-cycle pulse on the cycle the last word is written.
- `keys_valid` out 1: level; high from `done` until the next accepted `start` or reset.
- `rk_idx` in 4: round-key index to read, 0..NR.
- `rk_out` out [0:127]: registered round key {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]}.

## Operation

- State machine:
  - IDLE, on `start`=1: capture the key, go to EXPAND.
  - EXPAND, on the cycle word index i = TOTAL-1 is written: go to IDLE.
  - No other transitions.
- Accept cycle:
  - Words w[0..NK-1] = `key_in` are written to storage and loaded into an NK-word sliding window.
  - i = NK; rcon = 8'h01; `keys_valid` cleared; `busy` set.
- EXPAND, per cycle: compute w[i] from the window, write it to storage, shift it into the window, and increment i. With temp = w[i-1]:
  - i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}. After use, rcon = xtime(rcon) (shift left; XOR 8'h1B if bit 7 was set), giving 01,02,04,08,10,20,40,80,1B,36.
  - NK == 8 and i mod 8 == 4: temp = SubWord(temp).
  - Otherwise temp is used unchanged.
  - w[i] = w[i-NK] ^ temp.
- i mod NK is tracked with a wrap counter, not a divider; i is 6 bits wide.
- Exactly 4 sbox instances, shared between both SubWord cases.
- `start` while `busy` is ignored; no queuing and no restart.
- Read port: `rk_out` <= the 128-bit concatenation for `rk_idx` every cycle, regardless of state.
  - `rk_idx` > NR returns 128'h0.
  - Reading an index whose words are not yet written returns stale storage; the consumer must gate reads on `keys_valid`.
- Storage holds the last schedule until overwritten. A new accepted `start` overwrites it word by word.

## Timing

- Reset (async assert, sync deassert is the caller's responsibility):
  - State IDLE; `busy`=0, `done`=0, `keys_valid`=0, `rk_out`=0.
  - Counters and rcon cleared.
  - Storage contents are not cleared.
- Accept at edge T0: `busy`=1 from T0.
- Words are written at edges T1..T(TOTAL-NK).
- `done`=1 and `keys_valid`=1 after edge T(TOTAL-NK); `busy`=0 after the same edge.
- Latency from `start` edge to `done`: 40 cycles (128-bit), 46 (192-bit), 52 (256-bit).
- `start` may be reasserted on the cycle `done` is high; it is accepted at the next edge (back-to-back, zero idle cycles).
- Read latency: 1 cycle (`rk_idx` at edge N appears on `rk_out` after edge N).
- Reset mid-EXPAND: immediate return to IDLE with `keys_valid`=0. No `done` pulse is produced for the aborted run.

## Test plan

- Reset mid-run: assert `rst_n`=0 at cycle 10 of EXPAND -> all outputs 0 immediately. Then `start` again -> full correct schedule with `done` at 40 cycles.
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - `done` exactly 40 cycles after the `start` edge.
  - idx 1 -> a0fafe1788542cb123a339392a6c7605.
  - idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - idx 0 -> the key itself.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - `done` after 46 cycles.
  - idx 12 -> e98ba06f448c773c8ecc720401002202.
  - idx 13 -> 0.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - `done` after 52 cycles.
  - idx 14 -> fe4890d1e6188d0b046df344706c631e. This exercises the i mod 8 == 4 SubWord path.
- Handshake:
  - `start` pulsed while `busy` -> ignored; schedule and `done` timing unchanged.
  - `start` held on the `done` cycle with a new key -> `keys_valid` drops next cycle, and the new schedule completes 40 cycles later.
